bubble_sort_ctrl: RTL and testbench

Sequential bubble-sort engine for NUM unsigned WIDTH-bit values. It runs one compare-swap per clock over an internal register array under a small FSM, with a start/busy/done handshake. It sits between an input capture stage (switches or producer) and the display/consumer stage, which waits for done before reading sort_out.

---
 rtl/bubble_sort_pkg.sv | 20 ++
 rtl/bubble_sort_ctrl_compare_swap.sv | 17 +
 rtl/bubble_sort_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bubble_sort_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_sort_pkg.sv
// Shared definitions for the bubble-sort engine: FSM state encoding,
// default sizing and the swap-counter width helper.
package bubble_sort_pkg;

    localparam int NUM_DEF   = 4;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMP      = 2'd1,
        ST_PASS_END = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Width needed to count every swap of a worst-case (reversed) input.
    function automatic int swpw_f(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/bubble_sort_ctrl_compare_swap.sv
// Combinational compare-swap cell: orders one pair of unsigned values.
// Equal values are left in place, which keeps the sort stable.
module compare_swap #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Sequential bubble-sort engine: one compare-swap per clock over an internal
// register array, start/busy/done handshake, sorted result held until the
// next done. Define BUBBLE_SORT_EARLY_EXIT_EN to finish as soon as a full
// pass makes no swaps; by default every pass runs and latency is fixed.
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter  int NUM   = NUM_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int SWPW  = swpw_f(NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM*WIDTH-1:0] unsort_in,
    output logic                 busy,
    output logic                 done,
    output logic [NUM*WIDTH-1:0] sort_out,
    output logic [SWPW-1:0]      swap_cnt
);

    localparam int IW = $clog2(NUM);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] CMP      = ST_CMP;
    localparam logic [1:0] PASS_END = ST_PASS_END;
    localparam logic [1:0] DONE     = ST_DONE;

    localparam logic [IW-1:0] LAST_PASS = IW'(NUM - 2);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] arr_q [NUM];
    logic [WIDTH-1:0] arr_d [NUM];
    logic [WIDTH-1:0] sort_q [NUM];
    logic [WIDTH-1:0] sort_d [NUM];
    logic [WIDTH-1:0] unsort_arr [NUM];
    logic [IW-1:0]    pass_q, pass_d;
    logic [IW-1:0]    j_q, j_d;
    logic [IW-1:0]    jp1;
    logic [IW-1:0]    last_j;
    logic [SWPW-1:0]  cnt_q, cnt_d;
    logic [SWPW-1:0]  swap_cnt_q, swap_cnt_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    logic             swf_q, swf_d;
`endif
    logic [WIDTH-1:0] cs_lo, cs_hi;
    logic             cs_swap;

    // Flat port buses to/from per-element arrays.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_pack
            assign unsort_arr[gi]                 = unsort_in[gi*WIDTH +: WIDTH];
            assign sort_out[gi*WIDTH +: WIDTH]    = sort_q[gi];
        end
    endgenerate

    assign jp1    = j_q + 1'b1;
    // Each pass bubbles the largest remaining value to the top, so the
    // compare window shrinks by one per pass.
    assign last_j = LAST_PASS - pass_q;

    compare_swap #(.WIDTH(WIDTH)) u_cs (
        .a       (arr_q[j_q]),
        .b       (arr_q[jp1]),
        .lo      (cs_lo),
        .hi      (cs_hi),
        .swapped (cs_swap)
    );

    assign busy     = (state_q == CMP) || (state_q == PASS_END);
    assign done     = (state_q == DONE);
    assign swap_cnt = swap_cnt_q;

    // Next-state and datapath update for the sort FSM.
    always_comb begin
        state_d    = state_q;
        arr_d      = arr_q;
        sort_d     = sort_q;
        pass_d     = pass_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        swap_cnt_d = swap_cnt_q;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        swf_d      = swf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    arr_d   = unsort_arr;
                    pass_d  = '0;
                    j_d     = '0;
                    cnt_d   = '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                    swf_d   = 1'b0;
`endif
                    state_d = CMP;
                end
            end
            CMP: begin
                if (cs_swap) begin
                    arr_d[j_q] = cs_lo;
                    arr_d[jp1] = cs_hi;
                    cnt_d      = cnt_q + 1'b1;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                    swf_d      = 1'b1;
`endif
                end
                if (j_q == last_j) begin
                    state_d = PASS_END;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            PASS_END: begin
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                if ((pass_q == LAST_PASS) || !swf_q) begin
`else
                if (pass_q == LAST_PASS) begin
`endif
                    sort_d     = arr_q;
                    swap_cnt_d = cnt_q;
                    state_d    = DONE;
                end else begin
                    pass_d  = pass_q + 1'b1;
                    j_d     = '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                    swf_d   = 1'b0;
`endif
                    state_d = CMP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sort in flight and clears outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pass_q     <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            swap_cnt_q <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swf_q      <= 1'b0;
`endif
            for (int i = 0; i < NUM; i++) begin
                arr_q[i]  <= '0;
                sort_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            swap_cnt_q <= swap_cnt_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swf_q      <= swf_d;
`endif
            arr_q      <= arr_d;
            sort_q     <= sort_d;
        end
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl (NUM=4, WIDTH=4).
module tb_bubble_sort_ctrl;

    localparam int NUM = 4;
    localparam int W   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] unsort_in = '0;
    logic        busy, done;
    logic [15:0] sort_out;
    logic [2:0]  swap_cnt;

    int vectors = 0;
    int miscompares = 0;

    bubble_sort_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .unsort_in (unsort_in),
        .busy      (busy),
        .done      (done),
        .sort_out  (sort_out),
        .swap_cnt  (swap_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (specification level) ----------------
    function automatic logic [15:0] ref_sort(input logic [15:0] v);
        int q[$];
        logic [15:0] r;
        for (int k = 0; k < NUM; k++) q.push_back(int'(v[k*W +: W]));
        q.sort();
        r = '0;
        for (int k = 0; k < NUM; k++) r[k*W +: W] = q[k][W-1:0];
        return r;
    endfunction

    // Bubble sort performs exactly one swap per inverted pair.
    function automatic int ref_inv(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < NUM; i++)
            for (int k = i + 1; k < NUM; k++)
                if (v[i*W +: W] > v[k*W +: W]) n++;
        return n;
    endfunction

    function automatic int ref_lat(input logic [15:0] v);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        int p = 0;
        int passes;
        int lat = 0;
        for (int k = 0; k < NUM; k++) begin
            int c = 0;
            for (int i = 0; i < k; i++)
                if (v[i*W +: W] > v[k*W +: W]) c++;
            if (c > p) p = c;
        end
        passes = (p + 1 < NUM - 1) ? p + 1 : NUM - 1;
        for (int q = 0; q < passes; q++) lat += (NUM - 1 - q) + 1;
        return lat;
`else
        return (NUM - 1) * (NUM + 2) / 2;
`endif
    endfunction

    int          cyc = 0;
    int          d_edge = 0;
    int          last_done = -100;
    bit          act = 1'b0;
    logic [15:0] pend_sort = '0;
    int          pend_cnt = 0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [15:0] exp_sort = '0;
    int          exp_cnt = 0;

    // Model timeline: accept start when idle, publish result at the done edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= 0;
            act       <= 1'b0;
            last_done <= -100;
            d_edge    <= 0;
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_sort  <= '0;
            exp_cnt   <= 0;
        end else begin
            cyc      <= cyc + 1;
            exp_done <= 1'b0;
            if (!act) begin
                if (start && cyc >= last_done + 2) begin
                    act       <= 1'b1;
                    d_edge    <= cyc + ref_lat(unsort_in);
                    pend_sort <= ref_sort(unsort_in);
                    pend_cnt  <= ref_inv(unsort_in);
                    exp_busy  <= 1'b1;
                end
            end else if (cyc == d_edge) begin
                act       <= 1'b0;
                exp_busy  <= 1'b0;
                exp_done  <= 1'b1;
                exp_sort  <= pend_sort;
                exp_cnt   <= pend_cnt;
                last_done <= cyc;
            end
        end
    end

    // Cycle-by-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        chk("busy", {31'b0, busy}, {31'b0, exp_busy});
        chk("done", {31'b0, done}, {31'b0, exp_done});
        chk("sort_out", {16'b0, sort_out}, {16'b0, exp_sort});
        chk("swap_cnt", {29'b0, swap_cnt}, exp_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_sort(input logic [15:0] v, input logic [15:0] lit_out,
                            input int lit_cnt, input int lit_lat, input string tag);
        int n;
        bit seen;
        @(posedge clk); #1;
        unsort_in = v;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy0"}, {31'b0, busy}, 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_latency"}, n, lit_lat);
        chk({tag, "_sort_out"}, {16'b0, sort_out}, {16'b0, lit_out});
        chk({tag, "_swap_cnt"}, {29'b0, swap_cnt}, lit_cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        int t1, t2, c;
        logic [15:0] cap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sort_out", {16'b0, sort_out}, 32'd0);
        chk("rst_swap_cnt", {29'b0, swap_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: 9,3,7,1
        run_sort(16'h1739, 16'h9731, 5, 9, "t1");
        // 2: reversed 15,12,8,0
        run_sort(16'h08CF, 16'hFC80, 6, 9, "t2");
        // 3: already sorted with a duplicate 2,5,5,11
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
        run_sort(16'hB552, 16'hB552, 0, 4, "t3");
`else
        run_sort(16'hB552, 16'hB552, 0, 9, "t3");
`endif

        // 4: start and new data mid-sort must be ignored
        @(posedge clk); #1;
        unsort_in = 16'h1739;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        unsort_in = 16'h08CF;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        cap   = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap = sort_out;
            end
            @(posedge clk);
        end
        #1;
        chk("t4_done_count", ndone, 1);
        chk("t4_sort_out", {16'b0, cap}, 32'h9731);
        chk("t4_swap_cnt", {29'b0, swap_cnt}, 32'd5);

        // 5: reset mid-sort aborts, then a fresh sort
        @(posedge clk); #1;
        unsort_in = 16'h08CF;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_done", {31'b0, done}, 32'd0);
        chk("t5_rst_sort_out", {16'b0, sort_out}, 32'd0);
        chk("t5_rst_swap_cnt", {29'b0, swap_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_aborted_done", ndone, 0);
        run_sort(16'h0144, 16'h4410, 5, 9, "t5");

        // 6: start held high, done every latency+2 cycles
        @(posedge clk); #1;
        unsort_in = 16'h1739;
        start     = 1'b1;
        t1 = -1;
        t2 = -1;
        c  = 0;
        while (t2 < 0 && c < 60) begin
            @(negedge clk);
            c++;
            if (done) begin
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
        end
        start = 1'b0;
        chk("t6_two_dones", {31'b0, (t2 >= 0)}, 32'd1);
        chk("t6_spacing", t2 - t1, 11);
        repeat (15) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
